// File: rtl/delay_window_pkg.sv
// Shared types and helpers for the delay-window temporal checker.
package delay_window_pkg;

    typedef enum logic {
        PER_EVENT   = 1'b0,
        PER_ATTEMPT = 1'b1
    } count_mode_e;

    localparam int MAX_DLY_LIMIT = 32;
    localparam int POP_W         = 6;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_DLY_LIMIT-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_DLY_LIMIT; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a multi-bit increment; holds at all-ones.
module sat_counter #(
    parameter int W     = 8,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_o
);

    // One spare bit above the wider operand so the add can never wrap before the clamp.
    localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({W{1'b1}});

    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(cnt_o) + SUM_W'(inc_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (clear_i) begin
            cnt_o <= '0;
        end else if (sum > CNT_MAX) begin
            cnt_o <= '1;
        end else begin
            cnt_o <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/delay_window_monitor.sv
// Checker for a |-> ##[DLY_MIN:DLY_MAX] b with overlapping attempts and saturating stats.
// Define DELAY_WINDOW_MONITOR_SVA_EN to add the matching SVA properties and covers.
module delay_window_monitor
    import delay_window_pkg::*;
#(
    parameter int          DLY_MIN    = 1,
    parameter int          DLY_MAX    = 3,
    parameter count_mode_e COUNT_MODE = PER_EVENT,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             match_o,
    output logic             miss_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    if (DLY_MIN < 1) begin : g_bad_min
        $error("delay_window_monitor: DLY_MIN must be >= 1");
    end
    if ((DLY_MAX < DLY_MIN) || (DLY_MAX > MAX_DLY_LIMIT)) begin : g_bad_max
        $error("delay_window_monitor: DLY_MAX must be in [DLY_MIN, 32]");
    end

    // hist[k] set: an unresolved attempt was started k cycles ago.
    logic [DLY_MAX:1]         hist;
    logic [DLY_MAX:1]         hist_next;
    logic [DLY_MAX:1]         retire;
    logic [MAX_DLY_LIMIT-1:0] retire_ext;
    logic [POP_W-1:0]         match_inc;
    logic                     match_next;
    logic                     miss_next;

    always_comb begin
        retire    = '0;
        hist_next = '0;
        for (int k = 1; k <= DLY_MAX; k++) begin
            if (k >= DLY_MIN) begin
                retire[k] = b_i & hist[k];
            end
        end
        // A new attempt enters at age 1, so a same-cycle b can never retire it.
        hist_next[1] = a_i;
        for (int k = 1; k < DLY_MAX; k++) begin
            hist_next[k+1] = hist[k] & ~retire[k];
        end
        match_next = |retire;
        miss_next  = hist[DLY_MAX] & ~retire[DLY_MAX];
        retire_ext = MAX_DLY_LIMIT'(retire);
        match_inc  = (COUNT_MODE == PER_ATTEMPT) ? popcount(retire_ext) : POP_W'(match_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            match_o <= 1'b0;
            miss_o  <= 1'b0;
        end else if (clear_i) begin
            hist    <= '0;
            match_o <= 1'b0;
            miss_o  <= 1'b0;
        end else begin
            hist    <= hist_next;
            match_o <= match_next;
            miss_o  <= miss_next;
        end
    end

    assign pending_o = |hist;

    sat_counter #(
        .W    (CNT_W),
        .INC_W(POP_W)
    ) u_match_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear_i),
        .inc_i  (match_inc),
        .cnt_o  (match_cnt_o)
    );

    sat_counter #(
        .W    (CNT_W),
        .INC_W(1)
    ) u_miss_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear_i),
        .inc_i  (miss_next),
        .cnt_o  (miss_cnt_o)
    );

`ifdef DELAY_WINDOW_MONITOR_SVA_EN
    cov_a_then_b: cover property (@(posedge clk) disable iff (!rst_n)
        a_i ##[DLY_MIN:DLY_MAX] b_i);

    ast_match_has_b: assert property (@(posedge clk) disable iff (!rst_n)
        ($rose(match_o) || match_o) |-> $past(b_i));

    ast_miss_has_a: assert property (@(posedge clk) disable iff (!rst_n)
        miss_o |-> $past(a_i, DLY_MAX + 1));

    always @(posedge clk) begin
        if (rst_n) begin
            cov_miss: cover (miss_o);
        end
    end
`endif

endmodule

// File: tb/tb_delay_window_monitor.sv
// Bench for delay_window_monitor: three configurations share one stimulus stream.
module tb_delay_window_monitor;
    import delay_window_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;

    logic       ev_match, ev_miss, ev_pending;
    logic [7:0] ev_mcnt, ev_xcnt;
    logic       at_match, at_miss, at_pending;
    logic [7:0] at_mcnt, at_xcnt;
    logic       sat_match, sat_miss, sat_pending;
    logic [1:0] sat_mcnt, sat_xcnt;

    int n_cmp = 0;
    int n_bad = 0;

    // {match, miss, pending, ev match_cnt, ev miss_cnt, per-attempt match_cnt}
    logic [26:0] exp_q[$];
    logic [1:0]  sat_q[$];

    delay_window_monitor #(
        .DLY_MIN(2), .DLY_MAX(4), .COUNT_MODE(PER_EVENT), .CNT_W(8)
    ) u_ev (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b),
        .match_o(ev_match), .miss_o(ev_miss), .pending_o(ev_pending),
        .match_cnt_o(ev_mcnt), .miss_cnt_o(ev_xcnt)
    );

    delay_window_monitor #(
        .DLY_MIN(2), .DLY_MAX(4), .COUNT_MODE(PER_ATTEMPT), .CNT_W(8)
    ) u_at (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b),
        .match_o(at_match), .miss_o(at_miss), .pending_o(at_pending),
        .match_cnt_o(at_mcnt), .miss_cnt_o(at_xcnt)
    );

    delay_window_monitor #(
        .DLY_MIN(1), .DLY_MAX(1), .COUNT_MODE(PER_EVENT), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .a_i(a), .b_i(b),
        .match_o(sat_match), .miss_o(sat_miss), .pending_o(sat_pending),
        .match_cnt_o(sat_mcnt), .miss_cnt_o(sat_xcnt)
    );

    function automatic logic [26:0] pack(input logic m, input logic x, input logic p,
                                         input int mc, input int xc, input int ac);
        return {m, x, p, mc[7:0], xc[7:0], ac[7:0]};
    endfunction

    function automatic logic [26:0] obs();
        return {ev_match, ev_miss, ev_pending, ev_mcnt, ev_xcnt, at_mcnt};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic ta, input logic tb, input logic tc);
        a = ta;
        b = tb;
        clear = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        a = 1'b0;
        b = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a = 1'b1;
        b = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_ev: got %h expected %h", obs(), 27'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({at_match, at_miss, at_pending, at_xcnt} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_at: got %h expected 0", {at_match, at_miss, at_pending, at_xcnt});
        end
        n_cmp++;
        if ({sat_match, sat_miss, sat_pending, sat_mcnt, sat_xcnt} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_sat: got %h expected 0",
                     {sat_match, sat_miss, sat_pending, sat_mcnt, sat_xcnt});
        end
        apply_reset();
    endtask

    task automatic test_match();
        logic [5:0] a_seq = 6'b000001;
        logic [5:0] b_seq = 6'b001000;
        logic [26:0] e;
        apply_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        exp_q.push_back(pack(1, 0, 0, 1, 0, 1));
        exp_q.push_back(pack(0, 0, 0, 1, 0, 1));
        exp_q.push_back(pack(0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 6; i++) begin
            step(a_seq[i], b_seq[i], 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL match cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_miss();
        logic [6:0] a_seq = 7'b0000001;
        logic [6:0] b_seq = 7'b0000010;
        logic [26:0] e;
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        exp_q.push_back(pack(0, 1, 0, 0, 1, 0));
        exp_q.push_back(pack(0, 0, 0, 0, 1, 0));
        exp_q.push_back(pack(0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 7; i++) begin
            step(a_seq[i], b_seq[i], 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL miss cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_overlap();
        logic [7:0] a_seq = 8'b00000011;
        logic [7:0] b_seq = 8'b00001000;
        logic [26:0] e;
        apply_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        exp_q.push_back(pack(1, 0, 0, 1, 0, 2));
        for (int i = 0; i < 4; i++) exp_q.push_back(pack(0, 0, 0, 1, 0, 2));
        for (int i = 0; i < 8; i++) begin
            step(a_seq[i], b_seq[i], 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL overlap cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] e;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            sat_q.push_back((i < 3) ? 2'(i) : 2'd3);
            step(1'b1, 1'b0, 1'b0);
            e = sat_q.pop_front();
            n_cmp++;
            if (sat_xcnt !== e) begin
                n_bad++;
                $display("FAIL saturate cyc%0d: got %0d expected %0d", i, sat_xcnt, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [26:0] e;
        apply_reset();
        exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step(i == 0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL async_pre cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 27'd0) begin
            n_bad++;
            $display("FAIL async_now: got %h expected %h", obs(), 27'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0));
            step(1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL async_post cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_clear();
        logic [10:0] a_seq = 11'b00000100001;
        logic [10:0] c_seq = 11'b00000100000;
        logic [26:0] e;
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(pack(0, 0, 1, 0, 0, 0));
        exp_q.push_back(pack(0, 1, 0, 0, 1, 0));
        for (int i = 0; i < 6; i++) exp_q.push_back(pack(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++) begin
            step(a_seq[i], 1'b0, c_seq[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL clear cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
    endtask

    // Independent attempt-list model: each entry is the age of a live attempt.
    task automatic test_back_to_back();
        int ages[$];
        int nxt[$];
        int m_ev, m_at, x_c, nret;
        logic ra, rb, rc, m, x;
        logic [26:0] e;
        apply_reset();
        m_ev = 0;
        m_at = 0;
        x_c  = 0;
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 99) < 45);
            rb = ($urandom_range(0, 99) < 30);
            rc = ($urandom_range(0, 49) == 0);
            m = 1'b0;
            x = 1'b0;
            if (rc) begin
                ages.delete();
                m_ev = 0;
                m_at = 0;
                x_c  = 0;
            end else begin
                nret = 0;
                nxt.delete();
                foreach (ages[j]) begin
                    if (rb && ages[j] >= 2) nret++;
                    else if (ages[j] == 4) x = 1'b1;
                    else nxt.push_back(ages[j] + 1);
                end
                if (ra) nxt.push_back(1);
                ages = nxt;
                m = (nret > 0);
                m_ev = (m_ev + int'(m) > 255) ? 255 : m_ev + int'(m);
                m_at = (m_at + nret > 255) ? 255 : m_at + nret;
                x_c  = (x_c + int'(x) > 255) ? 255 : x_c + int'(x);
            end
            exp_q.push_back(pack(m, x, ages.size() > 0, m_ev, x_c, m_at));
            step(ra, rb, rc);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h expected %h", i, obs(), e);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_miss();
        test_overlap();
        test_saturate();
        test_async_reset();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/delay_window_monitor.md
Name: delay_window_monitor

Overview:
- Synthesizable checker for the temporal relation "a ##[DLY_MIN:DLY_MAX] b", equivalent to the SVA `a |-> ##[DLY_MIN:DLY_MAX] b`.
- Successor to the fixed single-delay FSM checker. Adds a programmable delay window, overlapping attempts, explicit misses, per-attempt or per-event match counting, and saturating statistics.
- Sits beside the DUT in formal and simulation benches. Match/miss pulses feed immediate `cover` and `assert` statements.

Parameters:
- DLY_MIN, 1: lowest accepted delay in cycles. Must be ≥1; elaboration error otherwise.
- DLY_MAX, 3: highest accepted delay. Must be ≥ DLY_MIN and ≤ 32; elaboration error otherwise.
- COUNT_MODE, PER_EVENT: PER_EVENT = +1 per matching b cycle; PER_ATTEMPT = +number of attempts retired by that b.
- CNT_W, 8: width of both statistic counters.

Ports:
- clk  in  1  sampling clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of attempts and counters.
- a_i  in  1  antecedent; starts one attempt per high cycle.
- b_i  in  1  consequent.
- match_o  out  1  one-cycle pulse: ≥1 attempt satisfied in the previous cycle.
- miss_o  out  1  one-cycle pulse: an attempt expired unsatisfied in the previous cycle.
- pending_o  out  1  ≥1 attempt in flight (combinational from state).
- match_cnt_o  out  CNT_W  saturating match count.
- miss_cnt_o  out  CNT_W  saturating miss count.

Behaviour:
- State is the attempt history hist[1..DLY_MAX]. hist[k]=1 means an unresolved attempt started k cycles ago.
- Window: the set of k with DLY_MIN ≤ k ≤ DLY_MAX.
- Retire: in cycle t, retire[k] = b_i & hist[k] for every k in the window. b_i does not affect ages below DLY_MIN; such a b is ignored for those attempts.
- Update at each clk edge:
  - hist[1] ← a_i.
  - hist[k+1] ← hist[k] & ~retire[k], for k = 1..DLY_MAX-1.
  - Attempt at DLY_MAX with no retire → expires.
- Registered outputs, latency 1:
  - match_o ← |retire.
  - miss_o ← hist[DLY_MAX] & ~retire[DLY_MAX].
  - match_cnt_o += 1 (PER_EVENT) or popcount(retire) (PER_ATTEMPT).
  - miss_cnt_o += miss.
- Saturation: counters hold at 2^CNT_W−1. Add with a CNT_W+1-bit intermediate and clamp.
- Simultaneous a_i and b_i: the new attempt is at age 0, so the same-cycle b never retires it. One b retires all attempts currently in the window.
- pending_o = |hist.
- clear_i: hist, counters, match_o and miss_o ← 0 at the next edge. clear_i takes priority over a_i in the same cycle. No miss is reported for cleared attempts.
- Reset: all state and outputs 0 immediately on rst_n low. Reset mid-attempt discards the attempt silently. First edge after release samples a_i normally.

Optional Feature:
- DELAY_WINDOW_MONITOR_SVA_EN defined:
  - Adds concurrent properties: cover `a_i ##[DLY_MIN:DLY_MAX] b_i`.
  - Adds assertion `$rose(match_o) or match_o |-> $past(b_i)`.
  - Adds assertion `miss_o |-> $past(a_i, DLY_MAX+1)`.
  - Adds an immediate cover on miss_o.
  - All disabled while rst_n is low.
- Undefined: no properties; pure RTL, usable in SVA-less flows.

Decomposition:
- Package delay_window_pkg:
  - count_mode_e enum {PER_EVENT, PER_ATTEMPT}.
  - MAX_DLY_LIMIT=32.
  - popcount function.
- Sub-module sat_counter (parameters W, INC_W):
  - Ports clk, rst_n, clear_i, inc_i, cnt_o.
  - Instantiated twice.

Test Plan:
- DLY 2..4, a@0, b@3 → match_o=1 @4, match_cnt_o=1, miss_o never, pending_o low from @4.
- DLY 2..4, a@0, b@1 only → no match; miss_o=1 @5, miss_cnt_o=1.
- DLY 2..4, a@0,1, b@3:
  - PER_EVENT → single match_o pulse @4, match_cnt_o=1.
  - PER_ATTEMPT → match_cnt_o=2.
  - Both modes → no miss.
- CNT_W=2, a every cycle, b never, DLY 1..1 → miss_cnt_o saturates at 3, stays 3.
- DLY 2..4, a@0, rst_n low @2 (async, mid-cycle) → all outputs 0 at once; no miss @5.
- a@0, clear_i@0 → clear wins, pending_o=0 @1, no miss.
